// File: rtl/alu_issue.sv
// alu_issue: decode/issue stage feeding the ALU operand interface.
// Reads the register file, registers op/a/b/imm into ID/EX, resolves BEQ via the
// ALU zero flag, inserts a bubble on load-use hazards and holds on downstream stall.
// Optional feature macro: ALU_MUL_MULTI_EN (multi-cycle MUL occupying EX for MUL_LAT cycles).

`ifndef DSIZE
`define DSIZE 16
`endif
`ifndef ADD
`define ADD 4'h0
`define SUB 4'h1
`define AND 4'h2
`define XOR 4'h3
`define SLL 4'h4
`define SRL 4'h5
`define COM 4'h6
`define MUL 4'h7
`define LW  4'h8
`define SW  4'h9
`define BEQ 4'hA
`endif

module alu_issue #(
    parameter int DSIZE   = `DSIZE,
    parameter int RSIZE   = 4,
    parameter int PSIZE   = 16,
    parameter int MUL_LAT = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_instr,
    input  logic [PSIZE-1:0] in_pc,
    output logic [RSIZE-1:0] rs_addr,
    output logic [RSIZE-1:0] rt_addr,
    input  logic [DSIZE-1:0] rs_data,
    input  logic [DSIZE-1:0] rt_data,
    input  logic             ex_ready,
    input  logic             zero,
    output logic             ex_valid,
    output logic [3:0]       ex_op,
    output logic [DSIZE-1:0] ex_a,
    output logic [DSIZE-1:0] ex_b,
    output logic [DSIZE-1:0] ex_imm,
    output logic [RSIZE-1:0] ex_rd,
    output logic             ex_wen,
    output logic             redirect,
    output logic [PSIZE-1:0] redirect_pc
);

    logic             ex_valid_q, ex_valid_d;
    logic [3:0]       ex_op_q, ex_op_d;
    logic [DSIZE-1:0] ex_a_q, ex_a_d;
    logic [DSIZE-1:0] ex_b_q, ex_b_d;
    logic [DSIZE-1:0] ex_imm_q, ex_imm_d;
    logic [RSIZE-1:0] ex_rd_q, ex_rd_d;
    logic             ex_wen_q, ex_wen_d;
    logic [PSIZE-1:0] ex_pc_q, ex_pc_d;

    logic [3:0]       in_op;
    logic [RSIZE-1:0] in_rd;
    logic [DSIZE-1:0] in_imm;
    logic             in_shift;
    logic             in_wen;
    logic             mul_busy;
    logic             hold;
    logic             load_use;
    logic             accept;

    assign in_op    = in_instr[15:12];
    assign in_rd    = RSIZE'(in_instr[11:8]);
    assign rs_addr  = RSIZE'(in_instr[7:4]);
    assign rt_addr  = RSIZE'(in_instr[3:0]);
    assign in_imm   = {{(DSIZE-4){1'b0}}, in_instr[3:0]};
    assign in_shift = (in_op == `SLL) || (in_op == `SRL);

    // Write-enable decode: only ops that produce a register result write rd
    always_comb begin
        case (in_op)
            `ADD, `SUB, `AND, `XOR, `SLL, `SRL, `COM, `MUL, `LW: in_wen = 1'b1;
            default:                                              in_wen = 1'b0;
        endcase
    end

`ifdef ALU_MUL_MULTI_EN
    localparam int CW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
    logic [CW-1:0] mul_cnt_q, mul_cnt_d;
    assign mul_busy = (mul_cnt_q != '0);
`else
    assign mul_busy = 1'b0;
`endif

    assign hold        = !ex_ready || mul_busy;
    assign redirect    = ex_valid_q && (ex_op_q == `BEQ) && zero && !hold;
    assign redirect_pc = redirect
                       ? ex_pc_q + PSIZE'(1) + {{(PSIZE-RSIZE){ex_rd_q[RSIZE-1]}}, ex_rd_q}
                       : '0;
    // Shifts take imm4 from the rt field, so rt is not a real source for them
    assign load_use    = ex_valid_q && (ex_op_q == `LW) &&
                         ((ex_rd_q == rs_addr) || (!in_shift && (ex_rd_q == rt_addr)));
    // A flush swallows the fetched instruction, so fetch sees it as consumed
    assign in_ready    = !hold && (redirect || !load_use);
    assign accept      = !hold && !redirect && !load_use && in_valid;

    // Next-state for ID/EX: hold > flush > load-use bubble > accept/idle
    always_comb begin
        ex_valid_d = ex_valid_q;
        ex_op_d    = ex_op_q;
        ex_a_d     = ex_a_q;
        ex_b_d     = ex_b_q;
        ex_imm_d   = ex_imm_q;
        ex_rd_d    = ex_rd_q;
        ex_wen_d   = ex_wen_q;
        ex_pc_d    = ex_pc_q;
        if (!hold) begin
            if (accept) begin
                ex_valid_d = 1'b1;
                ex_op_d    = in_op;
                ex_a_d     = rs_data;
                ex_b_d     = in_shift ? '0 : rt_data;
                ex_imm_d   = in_imm;
                ex_rd_d    = in_rd;
                ex_wen_d   = in_wen;
                ex_pc_d    = in_pc;
            end else begin
                ex_valid_d = 1'b0;
            end
        end
`ifdef ALU_MUL_MULTI_EN
        mul_cnt_d = mul_cnt_q;
        if (mul_cnt_q != '0) begin
            if (ex_ready) mul_cnt_d = mul_cnt_q - CW'(1);
        end else if (accept && (in_op == `MUL)) begin
            mul_cnt_d = CW'(MUL_LAT - 1);
        end
`endif
    end

    // ID/EX register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_q <= 1'b0;
            ex_op_q    <= `ADD;
            ex_a_q     <= '0;
            ex_b_q     <= '0;
            ex_imm_q   <= '0;
            ex_rd_q    <= '0;
            ex_wen_q   <= 1'b0;
            ex_pc_q    <= '0;
`ifdef ALU_MUL_MULTI_EN
            mul_cnt_q  <= '0;
`endif
        end else begin
            ex_valid_q <= ex_valid_d;
            ex_op_q    <= ex_op_d;
            ex_a_q     <= ex_a_d;
            ex_b_q     <= ex_b_d;
            ex_imm_q   <= ex_imm_d;
            ex_rd_q    <= ex_rd_d;
            ex_wen_q   <= ex_wen_d;
            ex_pc_q    <= ex_pc_d;
`ifdef ALU_MUL_MULTI_EN
            mul_cnt_q  <= mul_cnt_d;
`endif
        end
    end

    assign ex_valid = ex_valid_q;
    assign ex_op    = ex_op_q;
    assign ex_a     = ex_a_q;
    assign ex_b     = ex_b_q;
    assign ex_imm   = ex_imm_q;
    assign ex_rd    = ex_rd_q;
    assign ex_wen   = ex_wen_q;

endmodule

// File: tb/tb_alu_issue.sv
// Testbench for alu_issue: directed scenarios plus randomized traffic checked
// against a cycle-level behavioural model of the issue stage.

module tb_alu_issue;

    localparam logic [3:0] OP_ADD = 4'h0, OP_SUB = 4'h1, OP_AND = 4'h2, OP_XOR = 4'h3,
                           OP_SLL = 4'h4, OP_SRL = 4'h5, OP_COM = 4'h6, OP_MUL = 4'h7,
                           OP_LW  = 4'h8, OP_SW  = 4'h9, OP_BEQ = 4'hA;
    localparam int MUL_LAT = 3;
`ifdef ALU_MUL_MULTI_EN
    localparam bit MULTI = 1'b1;
`else
    localparam bit MULTI = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, in_valid, ex_ready, zero;
    logic [15:0] in_instr, in_pc, rs_data, rt_data;
    logic        in_ready, ex_valid, ex_wen, redirect;
    logic [3:0]  rs_addr, rt_addr, ex_op, ex_rd;
    logic [15:0] ex_a, ex_b, ex_imm, redirect_pc;

    alu_issue dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .rs_addr(rs_addr), .rt_addr(rt_addr),
        .rs_data(rs_data), .rt_data(rt_data), .ex_ready(ex_ready), .zero(zero),
        .ex_valid(ex_valid), .ex_op(ex_op), .ex_a(ex_a), .ex_b(ex_b), .ex_imm(ex_imm),
        .ex_rd(ex_rd), .ex_wen(ex_wen), .redirect(redirect), .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model of the instruction sitting in EX
    bit          m_known = 1'b0;
    bit          m_valid;
    logic [3:0]  m_op, m_rd;
    logic [15:0] m_a, m_b, m_imm, m_pc;
    bit          m_wen;
    int          m_left;  // further cycles a multi-cycle MUL must stay in EX

    logic        obs_ready, obs_redir;
    logic [15:0] obs_rpc;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] mk(input logic [3:0] op, rd, rs, rt);
        return {op, rd, rs, rt};
    endfunction

    function automatic bit writes_rd(input logic [3:0] op);
        return op == OP_ADD || op == OP_SUB || op == OP_AND || op == OP_XOR || op == OP_SLL ||
               op == OP_SRL || op == OP_COM || op == OP_MUL || op == OP_LW;
    endfunction

    task automatic step(input logic r, iv, input logic [15:0] ins, pc, rsd, rtd,
                        input logic rdy, z);
        logic [3:0]  op, rd, rs, rt;
        bit          shf, stall, take, lu;
        int          off;
        logic [15:0] tgt;
        @(negedge clk);
        rst = r; in_valid = iv; in_instr = ins; in_pc = pc;
        rs_data = rsd; rt_data = rtd; ex_ready = rdy; zero = z;
        {op, rd, rs, rt} = ins;
        shf   = (op == OP_SLL) || (op == OP_SRL);
        stall = !rdy || (MULTI && m_left > 0);
        take  = m_valid && m_op == OP_BEQ && z && !stall;
        off   = (m_rd >= 8) ? int'(m_rd) - 16 : int'(m_rd);
        tgt   = take ? 16'((int'(m_pc) + 1 + off) & 'hFFFF) : 16'h0;
        lu    = m_valid && m_op == OP_LW && (m_rd == rs || (!shf && m_rd == rt));
        #1;
        obs_ready = in_ready; obs_redir = redirect; obs_rpc = redirect_pc;
        chk("rs_addr", 32'(rs_addr), 32'(rs));
        chk("rt_addr", 32'(rt_addr), 32'(rt));
        if (m_known) begin
            chk("in_ready", 32'(in_ready), 32'(!stall && (take || !lu)));
            chk("redirect", 32'(redirect), 32'(take));
            chk("redirect_pc", 32'(redirect_pc), 32'(tgt));
        end
        if (r) begin
            m_known = 1'b1; m_valid = 0; m_op = OP_ADD; m_a = 0; m_b = 0; m_imm = 0;
            m_rd = 0; m_wen = 0; m_pc = 0; m_left = 0;
        end else if (stall) begin
            if (rdy && m_left > 0) m_left--;
        end else if (take || lu || !iv) begin
            m_valid = 0;
        end else begin
            m_valid = 1; m_op = op; m_rd = rd; m_pc = pc; m_a = rsd;
            m_b = shf ? 16'h0 : rtd; m_imm = {12'h0, rt}; m_wen = writes_rd(op);
            m_left = (MULTI && op == OP_MUL) ? MUL_LAT - 1 : 0;
        end
        @(posedge clk);
        #1;
        if (m_known) begin
            chk("ex_valid", 32'(ex_valid), 32'(m_valid));
            chk("ex_op", 32'(ex_op), 32'(m_op));
            chk("ex_a", 32'(ex_a), 32'(m_a));
            chk("ex_b", 32'(ex_b), 32'(m_b));
            chk("ex_rd", 32'(ex_rd), 32'(m_rd));
            chk("ex_wen", 32'(ex_wen), 32'(m_wen));
            if (m_op == OP_SLL || m_op == OP_SRL) chk("ex_imm", 32'(ex_imm), 32'(m_imm));
        end
    endtask

    initial begin
        int n;
        bit done;
        rst = 1; in_valid = 0; in_instr = 0; in_pc = 0; rs_data = 0; rt_data = 0;
        ex_ready = 1; zero = 0;

        step(1, 0, 16'h0, 16'h0, 16'h0, 16'h0, 1, 0);
        step(1, 0, 16'h0, 16'h0, 16'h0, 16'h0, 1, 0);

        // ADD r3,r1,r2
        step(0, 1, mk(OP_ADD, 3, 1, 2), 16'h0004, 16'd5, 16'd7, 1, 0);
        chk("add_valid", 32'(ex_valid), 32'd1);
        chk("add_a", 32'(ex_a), 32'd5);
        chk("add_b", 32'(ex_b), 32'd7);
        chk("add_rd", 32'(ex_rd), 32'd3);
        chk("add_wen", 32'(ex_wen), 32'd1);

        // Reset with a live instruction in EX
        step(1, 1, mk(OP_SUB, 2, 1, 1), 16'h0005, 16'd1, 16'd1, 1, 0);
        chk("rst_valid", 32'(ex_valid), 32'd0);
        chk("rst_op", 32'(ex_op), 32'(OP_ADD));
        step(0, 0, 16'h0, 16'h0, 16'h0, 16'h0, 1, 0);
        chk("rst_redirect", 32'(obs_redir), 32'd0);
        chk("rst_in_ready", 32'(obs_ready), 32'd1);

        // LW r4 then ADD r5,r4,r1: one bubble
        step(0, 1, mk(OP_LW, 4, 0, 0), 16'h0010, 16'h0, 16'h0, 1, 0);
        step(0, 1, mk(OP_ADD, 5, 4, 1), 16'h0011, 16'd9, 16'd2, 1, 0);
        chk("lu_stall", 32'(obs_ready), 32'd0);
        chk("lu_bubble", 32'(ex_valid), 32'd0);
        step(0, 1, mk(OP_ADD, 5, 4, 1), 16'h0011, 16'd9, 16'd2, 1, 0);
        chk("lu_resume", 32'(obs_ready), 32'd1);
        chk("lu_issue_rd", 32'(ex_rd), 32'd5);

        // LW r1 then SLL r5,r4,#1: rt field is an immediate, no stall
        step(0, 1, mk(OP_LW, 1, 0, 0), 16'h0012, 16'h0, 16'h0, 1, 0);
        step(0, 1, mk(OP_SLL, 5, 4, 1), 16'h0013, 16'h00F0, 16'h1234, 1, 0);
        chk("sll_no_stall", 32'(obs_ready), 32'd1);
        chk("sll_imm", 32'(ex_imm), 32'd1);
        chk("sll_b", 32'(ex_b), 32'd0);

        // BEQ at 0x0010, offset -3, taken
        step(0, 1, mk(OP_BEQ, 4'hD, 1, 2), 16'h0010, 16'd3, 16'd3, 1, 0);
        step(0, 1, mk(OP_ADD, 6, 1, 2), 16'h0011, 16'd1, 16'd1, 1, 1);
        chk("beq_redirect", 32'(obs_redir), 32'd1);
        chk("beq_target", 32'(obs_rpc), 32'h000E);
        chk("beq_flush", 32'(ex_valid), 32'd0);
        // Not taken
        step(0, 1, mk(OP_BEQ, 4'hD, 1, 2), 16'h0010, 16'd3, 16'd4, 1, 0);
        step(0, 1, mk(OP_ADD, 6, 1, 2), 16'h0011, 16'd1, 16'd1, 1, 0);
        chk("beq_nt_redirect", 32'(obs_redir), 32'd0);
        chk("beq_nt_issue", 32'(ex_valid && ex_op == OP_ADD), 32'd1);

        // Downstream stall for two cycles with SUB in EX
        step(0, 1, mk(OP_SUB, 2, 1, 3), 16'h0020, 16'd8, 16'd3, 1, 0);
        for (int i = 0; i < 2; i++) begin
            step(0, 1, mk(OP_ADD, 7, 1, 2), 16'h0021, 16'd4, 16'd4, 0, 0);
            chk("stall_in_ready", 32'(obs_ready), 32'd0);
            chk("stall_hold_op", 32'(ex_op), 32'(OP_SUB));
        end
        step(0, 1, mk(OP_ADD, 7, 1, 2), 16'h0021, 16'd4, 16'd4, 1, 0);
        chk("stall_release", 32'(ex_op), 32'(OP_ADD));

        // MUL followed by ADD
        step(0, 1, mk(OP_MUL, 6, 1, 2), 16'h0030, 16'd3, 16'd5, 1, 0);
        n = 0; done = 0;
        for (int i = 0; i < 10 && !done; i++) begin
            step(0, 1, mk(OP_ADD, 7, 1, 2), 16'h0031, 16'd1, 16'd1, 1, 0);
            n++;
            if (ex_valid && ex_op == OP_ADD) done = 1;
        end
        chk("add_after_mul_cycles", 32'(n), MULTI ? 32'd3 : 32'd1);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 99) == 0, $urandom_range(0, 9) < 8,
                 mk(4'($urandom_range(0, 15)), 4'($urandom_range(0, 3)),
                    4'($urandom_range(0, 3)), 4'($urandom_range(0, 3))),
                 16'($urandom), 16'($urandom), 16'($urandom),
                 $urandom_range(0, 9) < 8, 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
